// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply engine.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN
  } sa_state_e;

  function automatic int acc_width(input int data_width, input int k_max);
    return 2 * data_width + $clog2(k_max);
  endfunction

  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/sa_mac_pe.sv
// Signed multiply-accumulate PE with registered A/B forwarding.
// SA_SATURATE_EN selects clamping accumulation with a per-cycle clamp pulse.
module sa_mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
`ifdef SA_SATURATE_EN
  output logic                         sat,
`endif
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
`ifdef SA_SATURATE_EN
  logic signed [ACC_WIDTH:0]      sum;
  logic                           sat_i;
`endif

  always_comb begin
    a_d  = a_in;
    b_d  = b_in;
    prod = (2*DATA_WIDTH)'(a_in) * (2*DATA_WIDTH)'(b_in);
`ifdef SA_SATURATE_EN
    // One guard bit detects overflow; clamp toward the sign of the true sum.
    sum   = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod);
    sat_i = 1'b0;
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      sat_i = 1'b1;
      acc_d = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      acc_d = sum[ACC_WIDTH-1:0];
    end
    if (clr) begin
      sat_i = 1'b0;
    end
`else
    acc_d = acc_q + ACC_WIDTH'(prod);
`endif
    if (clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;
`ifdef SA_SATURATE_EN
  assign sat   = sat_i;
`endif

endmodule

// File: rtl/systolic_array_stream.sv
// NxN output-stationary systolic matmul: skewed operand streaming, row drain.
// Optional SA_SATURATE_EN adds clamping accumulation and the sticky sat_flag port.
module systolic_array_stream
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int K_MAX      = 256,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, K_MAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [N*DATA_WIDTH-1:0] a_col,
  input  logic [N*DATA_WIDTH-1:0] b_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*ACC_WIDTH-1:0]  out_row,
  output logic [$clog2(N)-1:0]    out_row_idx,
`ifdef SA_SATURATE_EN
  output logic                    sat_flag,
`endif
  output logic                    busy
);

  localparam int CW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);
  localparam int FL = flush_cycles(N);
  localparam int FW = $clog2(FL + 1);

  sa_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]  fl_q, fl_d;
  logic [RW-1:0]  row_q, row_d;
  logic           rdy_q, rdy_d;
  logic           accept, clr;

  logic signed [DATA_WIDTH-1:0] a_inj [N];
  logic signed [DATA_WIDTH-1:0] b_inj [N];
  logic signed [DATA_WIDTH-1:0] a_sk  [N];
  logic signed [DATA_WIDTH-1:0] b_sk  [N];
  logic signed [DATA_WIDTH-1:0] a_fw  [N][N];
  logic signed [DATA_WIDTH-1:0] b_fw  [N][N];
  logic signed [ACC_WIDTH-1:0]  acc_w [N][N];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fl_d      = fl_q;
    row_d     = row_q;
    rdy_d     = 1'b1;
    clr       = 1'b0;
    out_valid = 1'b0;
    in_ready  = rdy_q && (state_q == IDLE || state_q == LOAD);
    accept    = in_valid && in_ready;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (in_last || cnt_q == CW'(K_MAX - 1)) begin
            state_d = FLUSH;
            cnt_d   = '0;
            fl_d    = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        fl_d = fl_q + 1'b1;
        if (fl_q == FW'(FL - 1)) begin
          state_d = DRAIN;
          fl_d    = '0;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          row_d = row_q + 1'b1;
          if (row_q == RW'(N - 1)) begin
            row_d   = '0;
            clr     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fl_q    <= '0;
      row_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      row_q   <= row_d;
      rdy_q   <= rdy_d;
    end
  end

  // Non-accept cycles inject zeros so bubbles contribute nothing.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_inj[i] = accept ? a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      b_inj[i] = accept ? b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_sk[i] = a_inj[i];
      assign b_sk[i] = b_inj[i];
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] a_sh_q [i];
      logic signed [DATA_WIDTH-1:0] a_sh_d [i];
      logic signed [DATA_WIDTH-1:0] b_sh_q [i];
      logic signed [DATA_WIDTH-1:0] b_sh_d [i];

      always_comb begin
        a_sh_d[0] = a_inj[i];
        b_sh_d[0] = b_inj[i];
        for (int unsigned s = 1; s < i; s++) begin
          a_sh_d[s] = a_sh_q[s-1];
          b_sh_d[s] = b_sh_q[s-1];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned s = 0; s < i; s++) begin
            a_sh_q[s] <= '0;
            b_sh_q[s] <= '0;
          end
        end else begin
          for (int unsigned s = 0; s < i; s++) begin
            a_sh_q[s] <= a_sh_d[s];
            b_sh_q[s] <= b_sh_d[s];
          end
        end
      end

      assign a_sk[i] = a_sh_q[i-1];
      assign b_sk[i] = b_sh_q[i-1];
    end
  end

`ifdef SA_SATURATE_EN
  logic [N*N-1:0] sat_pe;
  logic           sat_q, sat_d;
`endif

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DATA_WIDTH-1:0] a_in_w, b_in_w;
      if (j == 0) begin : g_a_edge
        assign a_in_w = a_sk[i];
      end else begin : g_a_fwd
        assign a_in_w = a_fw[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in_w = b_sk[j];
      end else begin : g_b_fwd
        assign b_in_w = b_fw[i-1][j];
      end

      sa_mac_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .a_in (a_in_w),
        .b_in (b_in_w),
        .a_out(a_fw[i][j]),
        .b_out(b_fw[i][j]),
`ifdef SA_SATURATE_EN
        .sat  (sat_pe[i*N+j]),
`endif
        .acc  (acc_w[i][j])
      );
    end
  end

`ifdef SA_SATURATE_EN
  always_comb begin
    sat_d = clr ? 1'b0 : (sat_q | (|sat_pe));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`endif

  always_comb begin
    out_row = '0;
    if (state_q == DRAIN) begin
      for (int unsigned j = 0; j < N; j++) begin
        out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_w[row_q][j];
      end
    end
  end

  assign out_row_idx = row_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_array_stream.sv
// Self-checking bench: matrix-level reference model plus literal result pins.
module tb_systolic_array_stream;

  localparam int DW  = 8;
  localparam int N   = 2;
  localparam int KM  = 4;
  localparam int ACC = 2 * DW + $clog2(KM);
  localparam int RW  = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b0;
  logic [N*DW-1:0]   a_col = '0;
  logic [N*DW-1:0]   b_row = '0;
  logic              in_ready, out_valid, busy;
  logic [N*ACC-1:0]  out_row;
  logic [RW-1:0]     out_row_idx;
`ifdef SA_SATURATE_EN
  logic              sat_flag;
`endif

  systolic_array_stream #(
    .DATA_WIDTH(DW),
    .N         (N),
    .K_MAX     (KM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .a_col      (a_col),
    .b_row      (b_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_row_idx(out_row_idx),
`ifdef SA_SATURATE_EN
    .sat_flag   (sat_flag),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model state: operands of the open job, expected rows of the closed job.
  int               a_m [N][KM];
  int               b_m [KM][N];
  int               kcnt = 0;
  bit               closed = 0;
  bit               armed = 0;
  int               wait_c = 0;
  int               jobs_done = 0;
  bit               exp_sat = 0;
  logic [N*ACC-1:0] exp_q [$];
  logic [N*ACC-1:0] got_rows [N];

  function automatic void finish_job();
    logic [N*ACC-1:0] r;
    longint acc, lim_hi, lim_lo;
    lim_hi  = (longint'(1) <<< (ACC - 1)) - 1;
    lim_lo  = -(longint'(1) <<< (ACC - 1));
    exp_sat = 0;
    for (int i = 0; i < N; i++) begin
      r = '0;
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < kcnt; k++) begin
          acc += longint'(a_m[i][k]) * longint'(b_m[k][j]);
`ifdef SA_SATURATE_EN
          if (acc > lim_hi) begin acc = lim_hi; exp_sat = 1; end
          if (acc < lim_lo) begin acc = lim_lo; exp_sat = 1; end
`endif
        end
        r[j*ACC +: ACC] = acc[ACC-1:0];
      end
      exp_q.push_back(r);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_row", 64'(out_row), 64'd0);
      chk("rst_out_row_idx", 64'(out_row_idx), 64'd0);
`ifdef SA_SATURATE_EN
      chk("rst_sat_flag", 64'(sat_flag), 64'd0);
`endif
      kcnt   = 0;
      closed = 0;
      armed  = 0;
      exp_q.delete();
    end else begin
      chk("in_ready", 64'(in_ready), 64'(armed && !closed));
      chk("out_valid", 64'(out_valid), 64'(closed && wait_c == 0));
      chk("busy", 64'(busy), 64'(kcnt > 0 || closed));
      if (closed && wait_c == 0) begin
        chk("out_row", 64'(out_row), 64'(exp_q[0]));
        chk("out_row_idx", 64'(out_row_idx), 64'(N - exp_q.size()));
`ifdef SA_SATURATE_EN
        chk("sat_flag", 64'(sat_flag), 64'(exp_sat));
`endif
        if (out_ready) begin
          got_rows[N - exp_q.size()] = out_row;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            closed = 0;
            jobs_done++;
          end
        end
      end else if (closed) begin
        wait_c--;
      end
      if (armed && !closed && in_valid) begin
        for (int i = 0; i < N; i++) begin
          a_m[i][kcnt] = int'($signed(a_col[i*DW +: DW]));
          b_m[kcnt][i] = int'($signed(b_row[i*DW +: DW]));
        end
        kcnt++;
        if (in_last || kcnt == KM) begin
          finish_job();
          closed = 1;
          wait_c = 2 * N - 1;
          kcnt   = 0;
        end
      end
      armed = 1;
    end
  end

  // Downstream: 0 = always ready, 1 = random, 2 = stall 5 cycles per row.
  int rmode = 0;
  initial begin
    int st = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && st < 5) begin
            out_ready = 1'b0;
            st++;
          end else begin
            out_ready = out_valid;
            st = 0;
          end
        end
      endcase
    end
  end

  logic signed [DW-1:0] sa [N][KM];
  logic signed [DW-1:0] sb [KM][N];

  task automatic send_beat(input int k, input bit last, input int maxgap);
    int t;
    repeat ($urandom_range(0, maxgap)) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < N; i++) begin
      a_col[i*DW +: DW] = sa[i][k];
      b_row[i*DW +: DW] = sb[k][i];
    end
    in_valid = 1'b1;
    in_last  = last;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_jobs(input int target);
    int t = 0;
    while (jobs_done < target && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (jobs_done < target) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_job(input int k, input int maxgap);
    int target;
    target = jobs_done + 1;
    for (int b = 0; b < k; b++) send_beat(b, b == k - 1, maxgap);
    wait_jobs(target);
  endtask

  function automatic logic [N*ACC-1:0] row2(input int c0, input int c1);
    logic [N*ACC-1:0] r;
    r = '0;
    r[0 +: ACC]   = ACC'(c0);
    r[ACC +: ACC] = ACC'(c1);
    return r;
  endfunction

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KM; k++) begin
        sa[i][k] = DW'(av);
        sb[k][i] = DW'(bv);
      end
  endtask

  task automatic load_test1();
    sa[0][0] = 8'sd1; sa[1][0] = 8'sd3; sa[0][1] = 8'sd2; sa[1][1] = 8'sd4;
    sb[0][0] = 8'sd5; sb[0][1] = 8'sd6; sb[1][0] = 8'sd7; sb[1][1] = 8'sd8;
  endtask

  logic [N*ACC-1:0] ref_rows [N];

  initial begin
    int target;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    load_test1();
    run_job(2, 0);
    chk("t1_row0", 64'(got_rows[0]), 64'(row2(19, 22)));
    chk("t1_row1", 64'(got_rows[1]), 64'(row2(43, 50)));

    fill(-128, -128);
    run_job(4, 0);
    chk("neg128_row0", 64'(got_rows[0]), 64'(row2(65536, 65536)));
    chk("neg128_row1", 64'(got_rows[1]), 64'(row2(65536, 65536)));

    fill(-1, 127);
    run_job(4, 1);
    chk("m1x127_row0", 64'(got_rows[0]), 64'(row2(-508, -508)));
    chk("m1x127_row1", 64'(got_rows[1]), 64'(row2(-508, -508)));

    for (int i = 0; i < N; i++)
      for (int k = 0; k < KM; k++) begin
        sa[i][k] = DW'($urandom_range(0, 255));
        sb[k][i] = DW'($urandom_range(0, 255));
      end
    rmode = 0;
    run_job(3, 0);
    for (int r = 0; r < N; r++) ref_rows[r] = got_rows[r];
    rmode = 2;
    run_job(3, 3);
    for (int r = 0; r < N; r++) chk("bubble_vs_clean", 64'(got_rows[r]), 64'(ref_rows[r]));

    rmode = 0;
    fill(1, 1);
    target = jobs_done + 1;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = 8'sd1;
        b_row[i*DW +: DW] = 8'sd1;
      end
      in_valid = 1'b1;
      in_last  = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_jobs(target);
    chk("forced_row0", 64'(got_rows[0]), 64'(row2(4, 4)));
    chk("forced_row1", 64'(got_rows[1]), 64'(row2(4, 4)));

    fill(9, -7);
    send_beat(0, 1'b0, 0);
    send_beat(1, 1'b0, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    load_test1();
    run_job(2, 0);
    chk("post_rst_row0", 64'(got_rows[0]), 64'(row2(19, 22)));
    chk("post_rst_row1", 64'(got_rows[1]), 64'(row2(43, 50)));

    rmode = 1;
    for (int rep = 0; rep < 8; rep++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < KM; k++) begin
          sa[i][k] = DW'($urandom_range(0, 255));
          sb[k][i] = DW'($urandom_range(0, 255));
        end
      run_job($urandom_range(1, KM), 2);
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_array_stream.md
Name: systolic_array_stream

Overview:
- Parametrised NxN output-stationary systolic matrix-multiply engine; successor to the fixed 2x2 covariance datapath.
- Streams one k-slice per beat: column k of A and row k of B. Skews operands internally and accumulates C = A·B over a variable K.
- Drains C row by row over a ready/valid interface.
- Sits between the mean-centering stage and the eigen-solver in the covariance unit.

Parameters:
- DATA_WIDTH, 8, operand width, signed two's complement.
- N, 4, array dimension (N >= 2).
- K_MAX, 256, maximum beats per job.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K_MAX), accumulator/result width, signed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts a beat.
- in_last  in  1  marks final k beat of the job.
- a_col  in  N*DATA_WIDTH  A[i][k]; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_row  in  N*DATA_WIDTH  B[k][j]; lane j, same packing.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts row.
- out_row  out  N*ACC_WIDTH  C[r][j]; lane j at [j*ACC_WIDTH +: ACC_WIDTH].
- out_row_idx  out  $clog2(N)  row index r of out_row.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, async): state IDLE; all accumulators, skew registers and the beat counter are 0. Outputs: in_ready=0 while rst is low, then 1 from the first clock after release; out_valid=0, out_row=0, out_row_idx=0, busy=0. Reset mid-job aborts it with no partial output.
- A beat is accepted when in_valid && in_ready.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
  - IDLE: in_ready=1. Accepted beat with in_last=0 -> LOAD; with in_last=1 -> FLUSH.
  - LOAD: in_ready=1. Accepted beat with in_last=1, or accepted beat number K_MAX -> FLUSH. Reaching K_MAX forces last.
  - FLUSH: in_ready=0. Lasts exactly 2N-1 cycles, then -> DRAIN.
  - DRAIN: in_ready=0, out_valid=1. out_row and out_row_idx are held stable until out_ready. Each handshake advances the row. The handshake on row N-1 clears all accumulators the same cycle -> IDLE, so the next beat can be accepted the following cycle.
- Skew:
  - Lane i of a_col is delayed i cycles before entering PE(i,0).
  - Lane j of b_row is delayed j cycles before entering PE(0,j).
  - The array shifts every cycle. Cycles with no accepted beat inject zeros, so in_valid bubbles do not corrupt results.
- PE(i,j) rules:
  - Registered forwarding: A passes right, B passes down.
  - acc += sext(a)*sext(b). Products are full 2*DATA_WIDTH signed; accumulation wraps modulo 2^ACC_WIDTH.
  - PE(i,j) sees beat k at cycle t_k+i+j+1. The last contribution lands at t_last+2N-1, which matches the FLUSH length.
- out_row for row r = {acc[r][N-1] .. acc[r][0]}, driven registered or combinationally from the accumulators; both are allowed.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored.

Optional Feature:
- Macro SA_SATURATE_EN.
  - Defined: each accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], and a sticky output port sat_flag (1 bit) is added. sat_flag is set on any clamp, cleared at the row N-1 drain handshake and on reset.
  - Undefined: accumulation wraps and the sat_flag port is absent.

Decomposition:
- Package sa_pkg: FSM state enum (IDLE/LOAD/FLUSH/DRAIN), function acc_width(DATA_WIDTH,K_MAX), function flush_cycles(N)=2N-1.
- Sub-module sa_mac_pe: a single signed MAC PE with a_in/b_in, registered a_out/b_out, synchronous clr, acc output and the saturation option.
- The top level generates the NxN PE grid, the skew shift registers, the FSM and counters.

Test Plan:
- N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] (beats a_col={3,1},b_row={6,5}; a_col={4,2},b_row={8,7},last) -> rows idx0={19,22}, idx1={43,50}.
- Signed: N=2, K=4, all operands -128 -> every element 65536; repeat with A=-1, B=127 -> -508.
- Bubbles and backpressure: K=3 beats with in_valid gaps of 0-3 cycles; out_ready low for 5 cycles per row -> results identical to the gap-free run; out_row stable while stalled; in_ready=0 throughout FLUSH/DRAIN.
- Forced last: K_MAX=4, five beats of 1s offered with in_last=0 -> only 4 accepted; all elements =4; in_ready falls after the 4th.
- Reset mid-LOAD: assert rst after 2 beats, release, run the first test's job -> correct results with no residue; busy=0 and out_valid=0 during reset.
- SA_SATURATE_EN: ACC_WIDTH=16, K=4, operands 127×127 -> elements clamp to 32767 and sat_flag=1. Without the macro -> 64516 mod 2^16 = -1020 (signed).
